// File: rtl/k12a_run_ctl_pkg.sv
// Shared definitions for the K12A run/halt/step clock controller.
//   k12a_run_state_t : controller states
//   K12A_DIV_WIDTH   : default divider select / phase counter width
//   K12A_CNT_WIDTH   : default cpu_clock rising-edge counter width
package k12a_run_ctl_pkg;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUN      = 2'd1,
    STEP     = 2'd2,
    STEP_ACK = 2'd3
  } k12a_run_state_t;

  localparam int unsigned K12A_DIV_WIDTH = 8;
  localparam int unsigned K12A_CNT_WIDTH = 16;

endpackage

// File: rtl/k12a_run_ctl_clock_divider.sv
// k12a_clock_divider: phase counter and cpu_clock generator.
//   clk_i, rst_n_i   : sys_clock, async active-low reset
//   en_i             : count/toggle enable (controller in RUN or STEP)
//   load_i           : reload counter from div_sel_i while disabled
//   next_active_i    : controller will be active after this edge
//   div_sel_i        : sys_clock cycles per half-period, minus 1
//   cpu_clock_o      : registered CPU clock
//   rise_o           : this edge raises cpu_clock
//   period_end_o     : this edge lowers cpu_clock (end of a full period)
//   write_window_o   : high during the sys_clock period before a rising edge
module k12a_clock_divider
  import k12a_run_ctl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = K12A_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic                 next_active_i,
  input  logic [DIV_WIDTH-1:0] div_sel_i,
  output logic                 cpu_clock_o,
  output logic                 rise_o,
  output logic                 period_end_o,
  output logic                 write_window_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cpu_clock_q, cpu_clock_d;
  logic                 write_window_q, write_window_d;

  always_comb begin
    cnt_d        = cnt_q;
    cpu_clock_d  = cpu_clock_q;
    rise_o       = 1'b0;
    period_end_o = 1'b0;
    if (en_i) begin
      if (cnt_q == '0) begin
        cpu_clock_d  = ~cpu_clock_q;
        cnt_d        = div_sel_i;
        rise_o       = ~cpu_clock_q;
        period_end_o = cpu_clock_q;
      end else begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
      end
    end else begin
      cpu_clock_d = 1'b0;
      if (load_i) begin
        cnt_d = div_sel_i;
      end
    end
    // Predict from post-edge values: the window covers the cycle whose
    // ending edge will raise cpu_clock.
    write_window_d = next_active_i && !cpu_clock_d && (cnt_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q          <= '0;
      cpu_clock_q    <= 1'b0;
      write_window_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      cpu_clock_q    <= cpu_clock_d;
      write_window_q <= write_window_d;
    end
  end

  assign cpu_clock_o    = cpu_clock_q;
  assign write_window_o = write_window_q;

endmodule

// File: rtl/k12a_run_ctl.sv
// k12a_run_ctl: run/halt/single-step controller for the K12A CPU clock.
//   sys_clock, reset_n : system clock, async active-low reset
//   run_req            : level, free-run request
//   halt_req           : level, stop request (highest priority)
//   step_req/step_ack  : 4-phase single-step handshake
//   div_sel            : sys_clock cycles per cpu_clock half-period, minus 1
//   cpu_clock          : registered CPU clock, always stopped low
//   async_write        : sys_clock gated by the registered write window
//   halted             : core stopped (HALTED or STEP_ACK)
//   cycle_count        : cpu_clock rising edges, wrapping
module k12a_run_ctl
  import k12a_run_ctl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH    = K12A_DIV_WIDTH,
  parameter int unsigned CNT_WIDTH    = K12A_CNT_WIDTH,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic                 sys_clock,
  input  logic                 reset_n,
  input  logic                 run_req,
  input  logic                 halt_req,
  input  logic                 step_req,
  output logic                 step_ack,
  input  logic [DIV_WIDTH-1:0] div_sel,
  output logic                 cpu_clock,
  output logic                 async_write,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam k12a_run_state_t RESET_STATE = RUN_ON_RESET ? RUN : HALTED;

  k12a_run_state_t      state_q, state_d;
  logic                 load;
  logic                 active, next_active;
  logic                 rise, period_end;
  logic                 write_window;
  logic                 step_ack_q, halted_q;
  logic [CNT_WIDTH-1:0] cycle_count_q;

  assign active      = (state_q == RUN) || (state_q == STEP);
  assign next_active = (state_d == RUN) || (state_d == STEP);

  k12a_clock_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk_i         (sys_clock),
    .rst_n_i       (reset_n),
    .en_i          (active),
    .load_i        (load),
    .next_active_i (next_active),
    .div_sel_i     (div_sel),
    .cpu_clock_o   (cpu_clock),
    .rise_o        (rise),
    .period_end_o  (period_end),
    .write_window_o(write_window)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      HALTED: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (run_req) begin
          state_d = RUN;
          load    = 1'b1;
        end else if (step_req) begin
          state_d = STEP;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (period_end && (halt_req || !run_req)) state_d = HALTED;
      end
      STEP: begin
        if (period_end) state_d = STEP_ACK;
      end
      STEP_ACK: begin
        if (!step_req) state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RESET_STATE;
      step_ack_q    <= 1'b0;
      halted_q      <= !RUN_ON_RESET;
      cycle_count_q <= '0;
    end else begin
      state_q    <= state_d;
      step_ack_q <= (state_d == STEP_ACK);
      halted_q   <= (state_d == HALTED) || (state_d == STEP_ACK);
      if (rise) cycle_count_q <= cycle_count_q + CNT_WIDTH'(1);
    end
  end

  assign step_ack    = step_ack_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;
  assign async_write = sys_clock & write_window;

endmodule

// File: tb/tb_k12a_run_ctl.sv
// Self-checking bench for k12a_run_ctl (RUN_ON_RESET=1, default widths).
// The reference model tracks each cpu_clock half-period as a length and an
// elapsed-cycle count, and applies the controller rules per sys_clock edge.
module tb_k12a_run_ctl;

  logic        sys_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        run_req   = 1'b1;
  logic        halt_req  = 1'b0;
  logic        step_req  = 1'b0;
  logic        step_ack;
  logic [7:0]  div_sel   = 8'd0;
  logic        cpu_clock;
  logic        async_write;
  logic        halted;
  logic [15:0] cycle_count;

  k12a_run_ctl #(
    .DIV_WIDTH(8),
    .CNT_WIDTH(16),
    .RUN_ON_RESET(1'b1)
  ) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .div_sel    (div_sel),
    .cpu_clock  (cpu_clock),
    .async_write(async_write),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  always #5 sys_clock = ~sys_clock;

  int checks   = 0;
  int failures = 0;

  // Reference model
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_ACK = 3;
  int mode;
  bit clk_m;
  int elapsed;   // sys_clock cycles already spent in the current half-period
  int plen;      // length of the current half-period in sys_clock cycles
  int count_m;
  bit win_m;

  task automatic model_reset();
    mode    = M_RUN;
    clk_m   = 1'b0;
    elapsed = 0;
    plen    = 1;
    count_m = 0;
    win_m   = 1'b0;
  endtask

  task automatic model_step();
    int  nmode;
    bit  fell;
    nmode = mode;
    fell  = 1'b0;
    if (mode == M_RUN || mode == M_STEP) begin
      if (elapsed + 1 >= plen) begin
        fell    = clk_m;
        if (!clk_m) count_m = (count_m + 1) % 65536;
        clk_m   = !clk_m;
        elapsed = 0;
        plen    = int'(div_sel) + 1;
      end else begin
        elapsed++;
      end
    end
    case (mode)
      M_HALT: begin
        if (!halt_req && (run_req || step_req)) begin
          nmode   = run_req ? M_RUN : M_STEP;
          elapsed = 0;
          plen    = int'(div_sel) + 1;
        end
      end
      M_RUN:   if (fell && (halt_req || !run_req)) nmode = M_HALT;
      M_STEP:  if (fell) nmode = M_ACK;
      default: if (!step_req) nmode = M_HALT;
    endcase
    mode  = nmode;
    win_m = (mode == M_RUN || mode == M_STEP) && !clk_m && (elapsed + 1 == plen);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sys_clock edge: advance the model, then compare all outputs while
  // sys_clock is high so async_write reflects the write window.
  task automatic cycle();
    @(posedge sys_clock);
    model_step();
    #1;
    check("cpu_clock",   {31'd0, cpu_clock},   {31'd0, clk_m});
    check("cycle_count", {16'd0, cycle_count}, count_m);
    check("halted",      {31'd0, halted},      {31'd0, (mode == M_HALT || mode == M_ACK)});
    check("step_ack",    {31'd0, step_ack},    {31'd0, (mode == M_ACK)});
    check("async_write", {31'd0, async_write}, {31'd0, win_m});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model's cpu_clock is high; bounded.
  task automatic wait_cpu_high(input string tag);
    int n;
    n = 0;
    while (!clk_m && n < 64) begin
      cycle();
      n++;
    end
    check(tag, {31'd0, clk_m}, 32'd1);
  endtask

  int base;

  initial begin
    model_reset();
    #12;
    check("rst_cpu_clock",   {31'd0, cpu_clock},   32'd0);
    check("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    check("rst_step_ack",    {31'd0, step_ack},    32'd0);
    check("rst_halted",      {31'd0, halted},      32'd0);
    check("rst_async_write", {31'd0, async_write}, 32'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;

    // Free run, divide-by-1: 20 edges give 10 rising edges.
    cycles(20);
    check("div0_count10", {16'd0, cycle_count}, 32'd10);

    // div_sel=2: 3-cycle half-periods.
    #1 div_sel = 8'd2;
    cycles(14);

    // Change div_sel mid high phase.
    wait_cpu_high("wait_high_div");
    div_sel = 8'd0;
    cycles(8);

    // Halt mid high phase with div_sel=3.
    div_sel = 8'd3;
    cycles(9);
    wait_cpu_high("wait_high_halt");
    halt_req = 1'b1;
    base = count_m;
    cycles(12);
    check("halt_halted", {31'd0, halted},      32'd1);
    check("halt_cpu_lo", {31'd0, cpu_clock},   32'd0);
    check("halt_frozen", {16'd0, cycle_count}, base);

    // Single step held for 30 cycles with div_sel=1.
    halt_req = 1'b0;
    run_req  = 1'b0;
    div_sel  = 8'd1;
    step_req = 1'b1;
    base = count_m;
    cycles(30);
    check("step_count", {16'd0, cycle_count}, (base + 1) % 65536);
    check("step_ack_hold", {31'd0, step_ack}, 32'd1);
    step_req = 1'b0;
    cycles(1);
    check("step_ack_drop", {31'd0, step_ack}, 32'd0);
    cycles(6);
    check("no_second_step", {16'd0, cycle_count}, (base + 1) % 65536);

    // halt_req during STEP must not cut the step short.
    step_req = 1'b1;
    base = count_m;
    cycles(2);
    halt_req = 1'b1;
    cycles(10);
    check("step_halt_ack",   {31'd0, step_ack},    32'd1);
    check("step_halt_count", {16'd0, cycle_count}, (base + 1) % 65536);
    step_req = 1'b0;
    cycles(2);
    halt_req = 1'b0;

    // Randomized request levels and divider settings.
    for (int i = 0; i < 1500; i++) begin
      if (i % 7 == 0) begin
        halt_req = ($urandom_range(0, 5) == 0);
        run_req  = $urandom_range(0, 1) == 1;
        step_req = $urandom_range(0, 1) == 1;
        div_sel  = 8'($urandom_range(0, 3));
      end
      cycle();
    end

    // Asynchronous reset mid-run while cpu_clock is high.
    halt_req = 1'b0;
    step_req = 1'b0;
    run_req  = 1'b1;
    div_sel  = 8'd2;
    cycles(12);
    wait_cpu_high("wait_high_reset");
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_cpu_clock",   {31'd0, cpu_clock},   32'd0);
    check("async_rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;
    cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
